dct_job_sequencer: RTL

//  Sequences one 2-D DCT job on the 1-D DCT kernel datapath: issues N row-vector and N column-vector

---
 rtl/dct_job_sequencer_if.sv | 35 +++
 rtl/dct_job_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_job_sequencer_if.sv
// Kernel command/response bus of the 2-D DCT job sequencer.
// master = sequencer side, slave = 1-D DCT kernel side.
interface dct_job_sequencer_if #(
  parameter int MAX_LOG2_N = 6
);

  logic                  krn_valid;
  logic                  krn_ready;
  logic                  krn_pass;
  logic [MAX_LOG2_N-1:0] krn_index;
  logic [MAX_LOG2_N:0]   krn_len;
  logic                  krn_inverse;
  logic                  krn_resp_valid;

  modport master (
    output krn_valid,
    output krn_pass,
    output krn_index,
    output krn_len,
    output krn_inverse,
    input  krn_ready,
    input  krn_resp_valid
  );

  modport slave (
    input  krn_valid,
    input  krn_pass,
    input  krn_index,
    input  krn_len,
    input  krn_inverse,
    output krn_ready,
    output krn_resp_valid
  );

endinterface

// File: rtl/dct_job_sequencer.sv
// 2-D DCT job sequencer: N row + N column commands to the 1-D kernel,
// completion counting, abort drain, sticky status and interrupt.
module dct_job_sequencer #(
  parameter int MAX_LOG2_N      = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       cfg_start,
  input  logic [2:0] cfg_size,
  input  logic       cfg_inverse,
  input  logic       cfg_abort,
  input  logic       cfg_done_clr,
  output logic       stat_busy,
  output logic       stat_done,
  output logic       stat_err,
  output logic       stat_aborted,
  output logic       irq,
  dct_job_sequencer_if.master krn
);

  localparam int IW = MAX_LOG2_N;
  localparam int LW = MAX_LOG2_N + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [2:0] MAX_SIZE =
    3'(MAX_LOG2_N - 2);
  localparam logic [OW-1:0] OUT_MAX =
    OW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    IDLE,
    P1_ISSUE,
    P1_DRAIN,
    P2_ISSUE,
    P2_DRAIN,
    ABORT_DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LW-1:0] n_len;
  logic          inverse;
  logic [IW-1:0] issue_cnt;
  logic [LW-1:0] done_cnt;
  logic [OW-1:0] outstanding;

  logic done_r;
  logic err_r;
  logic aborted_r;
  logic irq_r;

  logic          issuing;
  logic          draining;
  logic          in_p2;
  logic          room;
  logic          cmd_valid;
  logic          hs;
  logic          resp_ok;
  logic          spurious;
  logic          size_ok;
  logic          start_ok;
  logic          start_bad;
  logic          abort_go;
  logic          last_issue;
  logic [IW-1:0] last_idx;
  logic [LW-1:0] done_nxt;
  logic          pass_done;
  logic [OW-1:0] out_nxt;
  logic          job_done;
  logic          abort_end;
  logic          cnt_clr;

  // Decode of the current state and handshake events.
  always_comb begin
    issuing   = (state == P1_ISSUE) ||
                (state == P2_ISSUE);
    draining  = (state == P1_DRAIN) ||
                (state == P2_DRAIN);
    in_p2     = (state == P2_ISSUE) ||
                (state == P2_DRAIN);
    room      = outstanding < OUT_MAX;
    cmd_valid = issuing && room;
    hs        = cmd_valid && krn.krn_ready;
    resp_ok   = krn.krn_resp_valid &&
                (outstanding != '0);
    spurious  = krn.krn_resp_valid &&
                (outstanding == '0);
    size_ok   = cfg_size <= MAX_SIZE;
    start_ok  = (state == IDLE) && cfg_start &&
                size_ok;
    start_bad = (state == IDLE) && cfg_start &&
                !size_ok;
    abort_go  = cfg_abort && (issuing || draining);
    last_idx  = IW'(n_len - LW'(1));
    last_issue = hs && (issue_cnt == last_idx);
    done_nxt  = done_cnt + LW'(resp_ok);
    pass_done = done_nxt == n_len;
  end

  // Commands in flight: a same-cycle accept and response cancel out.
  always_comb begin
    out_nxt = outstanding;
    if (hs && !resp_ok) begin
      out_nxt = outstanding + 1'b1;
    end else if (!hs && resp_ok) begin
      out_nxt = outstanding - 1'b1;
    end
  end

  // Job-level events: normal completion and end of abort drain.
  always_comb begin
    job_done  = (state == P2_DRAIN) && pass_done &&
                !cfg_abort;
    abort_end = (state == ABORT_DRAIN) &&
                (out_nxt == '0);
    cnt_clr   = start_ok || abort_end ||
                (draining && pass_done && !cfg_abort);
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort beats every other transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nxt = P1_ISSUE;
      end
      P1_ISSUE: begin
        if (abort_go) state_nxt = ABORT_DRAIN;
        else if (last_issue) state_nxt = P1_DRAIN;
      end
      P1_DRAIN: begin
        if (abort_go) state_nxt = ABORT_DRAIN;
        else if (pass_done) state_nxt = P2_ISSUE;
      end
      P2_ISSUE: begin
        if (abort_go) state_nxt = ABORT_DRAIN;
        else if (last_issue) state_nxt = P2_DRAIN;
      end
      P2_DRAIN: begin
        if (abort_go) state_nxt = ABORT_DRAIN;
        else if (pass_done) state_nxt = IDLE;
      end
      ABORT_DRAIN: begin
        if (out_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Kernel command outputs and busy flag.
  always_comb begin
    krn.krn_valid   = cmd_valid;
    krn.krn_pass    = inverse ^ in_p2;
    krn.krn_index   = issue_cnt;
    krn.krn_len     = n_len;
    krn.krn_inverse = inverse;
    stat_busy       = state != IDLE;
    stat_done       = done_r;
    stat_err        = err_r;
    stat_aborted    = aborted_r;
    irq             = irq_r;
  end

  // Job parameters captured on an accepted start.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      n_len   <= '0;
      inverse <= 1'b0;
    end else if (start_ok) begin
      n_len   <= LW'(4) << cfg_size;
      inverse <= cfg_inverse;
    end
  end

  // Issue/completion counters and in-flight count.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      issue_cnt   <= '0;
      done_cnt    <= '0;
      outstanding <= '0;
    end else begin
      outstanding <= out_nxt;
      if (cnt_clr) begin
        issue_cnt <= '0;
        done_cnt  <= '0;
      end else begin
        if (hs) issue_cnt <= issue_cnt + 1'b1;
        if (resp_ok && state != ABORT_DRAIN) begin
          done_cnt <= done_nxt;
        end
      end
    end
  end

  // Sticky status flags and the one-cycle interrupt.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      aborted_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      irq_r <= job_done || abort_end || start_bad;
      if (job_done) begin
        done_r <= 1'b1;
      end else if (cfg_done_clr || start_ok) begin
        done_r <= 1'b0;
      end
      if (spurious || start_bad) begin
        err_r <= 1'b1;
      end else if (start_ok) begin
        err_r <= 1'b0;
      end
      if (abort_end) begin
        aborted_r <= 1'b1;
      end else if (start_ok) begin
        aborted_r <= 1'b0;
      end
    end
  end

  // A stalled command must hold until it is accepted.
  ap_hold: assert property (
    @(posedge ACLK) disable iff (ARESET)
    (krn.krn_valid && !krn.krn_ready && !cfg_abort)
    |=> (krn.krn_valid && $stable(krn.krn_index))
  );

  // Never more commands in flight than the kernel allows.
  ap_room: assert property (
    @(posedge ACLK) disable iff (ARESET)
    outstanding <= OUT_MAX
  );

endmodule
